// File: rtl/gmii_port_router.sv
// Per-ingress-port GMII frame steerer: 15-cycle delay line, DA lookup, per-lane gating.
// Optional macro GMII_ROUTER_FILTER_SELF_EN drops frames whose DA is learned only on this port.

module gmii_router_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       dv,
  input  logic       err,
  output logic [7:0] out_data,
  output logic       out_dv,
  output logic       out_err
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_dv   <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      out_data <= en ? data : 8'h00;
      out_dv   <= en & dv;
      out_err  <= en & err;
    end
  end
endmodule

module gmii_port_router #(
  parameter int THIS_PORT_ROUTING = 0,
  parameter int PORT_NUMBER       = 4,
  parameter int TABLE_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [7:0]                            gmii_rxd_in_data,
  input  logic                                  gmii_rxd_in_dv,
  input  logic                                  gmii_rxd_in_err,
  input  logic [PORT_NUMBER*TABLE_DEPTH*48-1:0] src_MAC_table_mac,
  input  logic [PORT_NUMBER*TABLE_DEPTH-1:0]    src_MAC_table_valid,
  output logic [PORT_NUMBER*8-1:0]              gmii_rxd_out_data,
  output logic [PORT_NUMBER-1:0]                gmii_rxd_out_dv,
  output logic [PORT_NUMBER-1:0]                gmii_rxd_out_err
);
  localparam int DLY = 15;
  localparam logic [PORT_NUMBER-1:0] OWN = {{(PORT_NUMBER-1){1'b0}}, 1'b1} << THIS_PORT_ROUTING;

  logic                        discard;
  logic [3:0]                  cnt;
  logic [47:0]                 da;
  logic [PORT_NUMBER-1:0]      mask, mask_nxt, hit, other, pick;
  logic [DLY-1:0][7:0]         dl_data;
  logic [DLY-1:0]              vld_pipe, err_pipe;
  logic                        dv_eff, sof;
  logic [7:0]                  din;
  logic                        ein;

  // After a mid-frame reset, the tail of that frame is swallowed until dv drops.
  assign dv_eff = gmii_rxd_in_dv & ~discard;
  assign din    = discard ? 8'h00 : gmii_rxd_in_data;
  assign ein    = gmii_rxd_in_err & ~discard;

  // Byte 0 sitting at stage DLY-2 marks the decision edge; it exits on the next edge.
  assign sof = vld_pipe[DLY-2] & ~vld_pipe[DLY-1];

  always_comb begin
    hit = '0;
    for (int p = 0; p < PORT_NUMBER; p++)
      for (int e = 0; e < TABLE_DEPTH; e++)
        if (src_MAC_table_valid[p*TABLE_DEPTH+e] &&
            src_MAC_table_mac[(p*TABLE_DEPTH+e)*48 +: 48] == da)
          hit[p] = 1'b1;
    other = hit & ~OWN;
    pick  = '0;
    for (int p = PORT_NUMBER-1; p >= 0; p--)
      if (other[p]) begin
        pick    = '0;
        pick[p] = 1'b1;
      end
    // cnt below 14 at the decision edge means this frame ended before its DA completed.
    if (cnt != 4'd14)       mask_nxt = '0;
    else if (da[40])        mask_nxt = ~OWN;
    else if (|other)        mask_nxt = pick;
`ifdef GMII_ROUTER_FILTER_SELF_EN
    else if (|(hit & OWN))  mask_nxt = '0;
`endif
    else                    mask_nxt = ~OWN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard  <= 1'b1;
      cnt      <= '0;
      da       <= '0;
      mask     <= '0;
      dl_data  <= '0;
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      discard  <= discard & gmii_rxd_in_dv;
      cnt      <= dv_eff ? ((cnt == 4'd14) ? 4'd14 : cnt + 4'd1) : 4'd0;
      if (dv_eff && cnt >= 4'd8 && cnt <= 4'd13)
        da <= {da[39:0], gmii_rxd_in_data};
      dl_data  <= {dl_data[DLY-2:0], din};
      vld_pipe <= {vld_pipe[DLY-2:0], dv_eff};
      err_pipe <= {err_pipe[DLY-2:0], ein};
      if (sof)
        mask <= mask_nxt;
    end
  end

  for (genvar p = 0; p < PORT_NUMBER; p++) begin : g_lane
    gmii_router_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (mask[p]),
      .data     (dl_data[DLY-1]),
      .dv       (vld_pipe[DLY-1]),
      .err      (err_pipe[DLY-1]),
      .out_data (gmii_rxd_out_data[p*8 +: 8]),
      .out_dv   (gmii_rxd_out_dv[p]),
      .out_err  (gmii_rxd_out_err[p])
    );
  end
endmodule

// File: tb/tb_gmii_port_router.sv
// Bench for gmii_port_router: directed frames plus randomized traffic against a frame-level model.
module tb_gmii_port_router;
  localparam int PN = 4, TD = 4, THIS = 0, MAXC = 20000;
`ifdef GMII_ROUTER_FILTER_SELF_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rxd = '0;
  logic rxdv = 1'b0, rxer = 1'b0;
  logic [PN*TD*48-1:0] tmac = '0;
  logic [PN*TD-1:0]    tvld = '0;
  logic [PN*8-1:0]     odata;
  logic [PN-1:0]       odv, oerr;

  always #5 clk = ~clk;

  gmii_port_router #(.THIS_PORT_ROUTING(THIS), .PORT_NUMBER(PN), .TABLE_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .gmii_rxd_in_data(rxd), .gmii_rxd_in_dv(rxdv), .gmii_rxd_in_err(rxer),
    .src_MAC_table_mac(tmac), .src_MAC_table_valid(tvld),
    .gmii_rxd_out_data(odata), .gmii_rxd_out_dv(odv), .gmii_rxd_out_err(oerr)
  );

  int vecs = 0, errs = 0, cyc = 0;
  bit          h_rst [MAXC];
  int          h_fid [MAXC];
  logic [7:0]  h_data[MAXC];
  bit          h_err [MAXC];
  logic [PN-1:0] fmask[4096];
  int nfr = 0, cur = -1, kb = 0;
  bit discarding = 1'b1, prev_acc = 1'b0;
  logic [47:0] fda = '0;
  int lane_cnt[PN];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Forwarding decision straight from the routing rules.
  function automatic logic [PN-1:0] route(input logic [47:0] da);
    logic [PN-1:0] flood;
    bit own;
    flood = '1;
    flood[THIS] = 1'b0;
    own = 1'b0;
    if (da[40]) return flood;
    for (int p = 0; p < PN; p++)
      for (int e = 0; e < TD; e++)
        if (tvld[p*TD+e] && tmac[(p*TD+e)*48 +: 48] == da) begin
          if (p != THIS) begin
            logic [PN-1:0] oh;
            oh = '0;
            oh[p] = 1'b1;
            return oh;
          end
          own = 1'b1;
        end
    if (own && FILT) return '0;
    return flood;
  endfunction

  // Output at edge c is the byte accepted at edge c-15, if no reset hit it in between.
  function automatic logic [63:0] expect_out(input int c);
    logic [PN*8-1:0] d;
    logic [PN-1:0] v, e;
    int s;
    bit live;
    d = '0; v = '0; e = '0; s = c - 15;
    if (s >= 0 && h_fid[s] >= 0) begin
      live = 1'b1;
      for (int i = s + 1; i <= c; i++) if (h_rst[i]) live = 1'b0;
      if (live)
        for (int p = 0; p < PN; p++)
          if (fmask[h_fid[s]][p]) begin
            d[p*8 +: 8] = h_data[s];
            v[p] = 1'b1;
            e[p] = h_err[s];
          end
    end
    return 64'({d, v, e});
  endfunction

  task automatic cycle(input bit dv, input logic [7:0] d, input bit e, input bit r);
    bit acc;
    rxdv = dv; rxd = d; rxer = e; rst = r;
    if (r) begin
      #1;
      chk("rst_async", 64'({odata, odv, oerr}), 64'd0);
    end
    @(posedge clk);
    h_rst[cyc] = r; h_data[cyc] = d; h_err[cyc] = e; h_fid[cyc] = -1;
    if (r) begin
      discarding = 1'b1;
      prev_acc = 1'b0;
    end else begin
      acc = dv && !discarding;
      if (!dv) discarding = 1'b0;
      if (acc) begin
        if (!prev_acc) begin
          cur = nfr; nfr++; fmask[cur] = '0; kb = 0;
        end
        h_fid[cyc] = cur;
        if (kb >= 8 && kb <= 13) fda[(13-kb)*8 +: 8] = d;
        if (kb == 13) fmask[cur] = route(fda);
        kb++;
      end
      prev_acc = acc;
    end
    @(negedge clk);
    chk("lanes", 64'({odata, odv, oerr}), expect_out(cyc));
    for (int p = 0; p < PN; p++) lane_cnt[p] += int'(odv[p]);
    cyc++;
    if (cyc >= MAXC || nfr >= 4096) begin
      $display("FAIL budget: cycle %0d frames %0d exceeded", cyc, nfr);
      $fatal(1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [47:0] da, input int len, input int err_at,
                            input int rst_at, input int gap);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      if (k < 7)       b = 8'h55;
      else if (k == 7) b = 8'hD5;
      else if (k < 14) b = da[(13-k)*8 +: 8];
      else             b = 8'($urandom);
      cycle(1'b1, b, k == err_at, k == rst_at);
    end
    idle(gap);
  endtask

  task automatic set_ent(input int p, input int e, input logic [47:0] m, input bit v);
    tmac[(p*TD+e)*48 +: 48] = m;
    tvld[p*TD+e] = v;
  endtask

  task automatic clear_counts();
    for (int p = 0; p < PN; p++) lane_cnt[p] = 0;
  endtask

  task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
    int ex[PN];
    ex[0] = c0; ex[1] = c1; ex[2] = c2; ex[3] = c3;
    idle(18);
    for (int p = 0; p < PN; p++) chk(tag, 64'(lane_cnt[p]), 64'(ex[p]));
    clear_counts();
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] UNI22 = 48'h0200_0000_0022;
  localparam logic [47:0] UNK99 = 48'h0200_0000_0099;
  localparam logic [47:0] MAC_A = 48'h0200_0000_0011;
  localparam logic [47:0] MAC_B = 48'h0200_0000_0033;
  localparam logic [47:0] SELF  = 48'h0200_0000_0000;

  initial begin
    logic [47:0] pool[6];
    logic [47:0] da;
    int len, gap, ea, ra, sel;
    clear_counts();
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_state", 64'({odata, odv, oerr}), 64'd0);
    idle(3);

    send_frame(BCAST, 64, -1, -1, 1);
    check_counts("bcast", 0, 64, 64, 64);

    set_ent(2, 1, UNI22, 1'b1);
    send_frame(UNI22, 64, -1, -1, 1);
    check_counts("unicast", 0, 0, 64, 0);

    tvld = '0; tmac = '0;
    send_frame(UNK99, 64, -1, -1, 1);
    check_counts("unknown", 0, 64, 64, 64);

    set_ent(2, 1, UNI22, 1'b1);
    send_frame(UNI22, 10, -1, -1, 1);
    send_frame(UNI22, 40, -1, -1, 1);
    check_counts("runt_then_ok", 0, 0, 40, 0);

    set_ent(1, 0, MAC_A, 1'b1);
    set_ent(3, 2, MAC_B, 1'b1);
    send_frame(MAC_A, 50, -1, -1, 1);
    send_frame(MAC_B, 45, -1, -1, 1);
    check_counts("back2back", 0, 50, 0, 45);

    set_ent(3, 0, MAC_A, 1'b1);
    set_ent(0, 1, MAC_A, 1'b1);
    send_frame(MAC_A, 30, -1, -1, 1);
    check_counts("lowest_wins", 0, 30, 0, 0);

    set_ent(0, 3, SELF, 1'b1);
    send_frame(SELF, 64, 20, -1, 1);
    check_counts("self_err", 0, FILT ? 0 : 64, FILT ? 0 : 64, FILT ? 0 : 64);

    send_frame(SELF, 64, 20, 30, 1);
    check_counts("self_rst", 0, FILT ? 0 : 15, FILT ? 0 : 15, FILT ? 0 : 15);

    send_frame(BCAST, 30, -1, -1, 1);
    check_counts("after_rst", 0, 30, 30, 30);

    for (int i = 0; i < 6; i++) pool[i] = {8'h02, 32'h0, 8'(i + 1)};
    repeat (3) begin
      idle(4);
      for (int p = 0; p < PN; p++)
        for (int e = 0; e < TD; e++)
          set_ent(p, e, pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
      repeat (40) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      da = BCAST;
        else if (sel == 1) da = {24'h01005E, 24'($urandom)};
        else if (sel == 2) da = {8'h02, 40'($urandom)};
        else               da = pool[$urandom_range(0, 5)];
        len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 13) : $urandom_range(14, 80);
        ea  = $urandom_range(0, len + 5);
        ra  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
        gap = $urandom_range(1, 3);
        send_frame(da, len, ea, ra, gap);
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
